bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_pkg.sv | 54 +++++
 rtl/timer_prescaler.sv | 34 +++
 rtl/bus_timer.sv | 165 ++++++++++++++++
 tb/tb_bus_timer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: definitions shared by every responder on the simple CE/WE bus.
// Holds the word offsets for the timer register map, the CTRL and STATUS bit
// positions, the access-size (HB) encodings, and helpers that turn an access
// size plus address into byte enables and merge write data into a register.
package bus_pkg;

    // Word offsets, taken from address bits [4:2].
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int CTRL_WIDTH           = 3;

    // STATUS bit positions.
    localparam int STATUS_MATCH_BIT = 0;

    // Access size encodings carried on the HB field.
    typedef enum logic [1:0] {
        HB_BYTE     = 2'b00,
        HB_HALF     = 2'b01,
        HB_WORD     = 2'b10,
        HB_WORD_ALT = 2'b11   // decoded exactly like HB_WORD
    } bus_hb_e;

    // Byte enables for an access of size hb at byte offset addr_lo.
    function automatic logic [3:0] byte_enables(input logic [1:0] hb,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        case (hb)
            HB_BYTE: be = 4'b0001 << addr_lo;
            HB_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replace the enabled byte lanes of old_word with the matching lanes of wdata.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by (limit + 1) while enabled.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst_n   - asynchronous active-low reset
//   en      - count enable; when low the counter is held at 0
//   restart - forces the counter back to 0 (used when the divisor is rewritten)
//   limit   - terminal value; the counter runs 0..limit
//   tick    - high for one cycle each time the counter sits at limit while enabled
module timer_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        restart,
    input  logic [15:0] limit,
    output logic        tick
);

    logic [15:0] cnt;

    // tick is combinational so the consumer acts on it in the same cycle the
    // counter reaches limit; a limit of 0 therefore ticks every enabled cycle.
    assign tick = en && (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 32-bit timer with prescaler, compare match and IRQ.
// Register map (word offset = i_BUS_ADDR[4:2]):
//   0 CTRL     bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//   1 PRESCALE [15:0] clock divisor minus one
//   2 COUNT    32-bit counter, advanced on each prescaler tick
//   3 COMPARE  32-bit match value (resets to all ones)
//   4 STATUS   bit0 MATCH, sticky, write 1 to clear
//   5..7       read 0, writes ignored
// Ports:
//   i_clk, i_rst_n   - clock and asynchronous active-low reset
//   i_BUS_CE         - an access is presented this cycle
//   i_BUS_WE         - 1 write, 0 read
//   i_BUS_ADDR       - byte address, bits [4:0] decoded
//   i_BUS_WDATA      - write data in natural byte lanes
//   i_BUS_HB         - access size (byte, halfword, word)
//   o_BUS_RDATA      - registered read data
//   o_IRQ            - registered level interrupt, MATCH & IRQ_EN
//
// Bus access semantics: a transfer is presented and accepted in every cycle
// where i_BUS_CE=1; the responder has no wait states, so it is always ready.
// A write takes effect at the clock edge that ends the cycle. A read returns
// the full aligned word on o_BUS_RDATA after that edge and the value holds
// until the next read. With i_BUS_CE=0 the bus inputs are ignored.
module bus_timer
    import bus_pkg::*;
#(
    parameter int BASE_SLOT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_BUS_CE,
    input  logic        i_BUS_WE,
    input  logic [31:0] i_BUS_ADDR,
    input  logic [31:0] i_BUS_WDATA,
    input  logic [1:0]  i_BUS_HB,
    output logic [31:0] o_BUS_RDATA,
    output logic        o_IRQ
);

    // BASE_SLOT only records which chip-enable line selects this block.
    localparam int unused_base_slot = BASE_SLOT;

    logic                  unused_addr_hi;
    assign unused_addr_hi = ^i_BUS_ADDR[31:5];

    logic [CTRL_WIDTH-1:0] ctrl;
    logic [15:0]           prescale;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;
    logic                  tick;

    logic [2:0]  offset;
    logic        wr_en;
    logic        rd_en;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic [3:0]  be;
    logic [31:0] cur_word;
    logic [31:0] wr_word;
    logic        match_evt;
    logic        match_clr;

    assign offset      = i_BUS_ADDR[4:2];
    assign wr_en       = i_BUS_CE && i_BUS_WE;
    assign rd_en       = i_BUS_CE && !i_BUS_WE;
    assign wr_ctrl     = wr_en && (offset == OFF_CTRL);
    assign wr_prescale = wr_en && (offset == OFF_PRESCALE);
    assign wr_count    = wr_en && (offset == OFF_COUNT);
    assign wr_compare  = wr_en && (offset == OFF_COMPARE);
    assign wr_status   = wr_en && (offset == OFF_STATUS);
    assign be          = byte_enables(i_BUS_HB, i_BUS_ADDR[1:0]);

    // Current contents of the addressed register; feeds both the read path
    // and the byte-lane merge for writes.
    always_comb begin
        cur_word = '0;
        case (offset)
            OFF_CTRL:     cur_word = {{(32-CTRL_WIDTH){1'b0}}, ctrl};
            OFF_PRESCALE: cur_word = {16'd0, prescale};
            OFF_COUNT:    cur_word = count;
            OFF_COMPARE:  cur_word = compare;
            OFF_STATUS:   cur_word[STATUS_MATCH_BIT] = match;
            default:      cur_word = '0;
        endcase
    end

    assign wr_word = merge_lanes(cur_word, i_BUS_WDATA, be);

    // The match comparison uses COUNT as it stands before this edge.
    assign match_evt = tick && (count == compare);
    // MATCH sits in byte lane 0, so only accesses that enable lane 0 clear it.
    assign match_clr = wr_status && be[0] && i_BUS_WDATA[STATUS_MATCH_BIT];

    timer_prescaler u_prescaler (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .en      (ctrl[CTRL_EN_BIT]),
        .restart (wr_prescale),
        .limit   (prescale),
        .tick    (tick)
    );

    // Configuration registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl     <= '0;
            prescale <= '0;
            compare  <= 32'hFFFF_FFFF;
        end else begin
            if (wr_ctrl) begin
                ctrl <= wr_word[CTRL_WIDTH-1:0];
            end
            if (wr_prescale) begin
                prescale <= wr_word[15:0];
            end
            if (wr_compare) begin
                compare <= wr_word;
            end
        end
    end

    // COUNT: a bus write wins over a tick in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wr_word;
        end else if (tick) begin
            if (match_evt && ctrl[CTRL_AUTO_RELOAD_BIT]) begin
                count <= '0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

    // MATCH: a hardware set wins over a simultaneous write-1-to-clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            match <= 1'b0;
        end else if (match_evt) begin
            match <= 1'b1;
        end else if (match_clr) begin
            match <= 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_BUS_RDATA <= '0;
            o_IRQ       <= 1'b0;
        end else begin
            if (rd_en) begin
                o_BUS_RDATA <= cur_word;
            end
            o_IRQ <= match && ctrl[CTRL_IRQ_EN_BIT];
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: self-checking bench for bus_timer.
module tb_bus_timer;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_ce = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [1:0]  bus_hb = '0;
    logic [31:0] bus_rdata;
    logic        irq;

    always #5 clk = ~clk;

    bus_timer #(.BASE_SLOT(0)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_BUS_CE    (bus_ce),
        .i_BUS_WE    (bus_we),
        .i_BUS_ADDR  (bus_addr),
        .i_BUS_WDATA (bus_wdata),
        .i_BUS_HB    (bus_hb),
        .o_BUS_RDATA (bus_rdata),
        .o_IRQ       (irq)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Register-level view of the timer; the prescaler is a plain phase count.
    logic [2:0]  m_ctrl;
    logic [15:0] m_psc;
    int unsigned m_phase;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_match;
    logic [31:0] m_rdata;
    logic        m_irq;

    function automatic void model_reset();
        m_ctrl = '0; m_psc = '0; m_phase = 0; m_count = '0;
        m_cmp = 32'hFFFF_FFFF; m_match = 1'b0; m_rdata = '0; m_irq = 1'b0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] hb, input logic [1:0] a);
        if (hb == 2'b00)      return 32'hFF << (8 * a);
        else if (hb == 2'b01) return a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        else                  return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return {16'd0, m_psc};
            3'd2:    return m_count;
            3'd3:    return m_cmp;
            3'd4:    return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input logic ce, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [1:0] hb);
        logic [2:0]  off  = addr[4:2];
        logic [31:0] mask = lane_mask(hb, addr[1:0]);
        logic        wr   = ce && we;
        logic        en   = m_ctrl[0];
        logic        tick = en && (m_phase == int'(m_psc));
        logic        hit  = tick && (m_count == m_cmp);
        logic [31:0] merged = (model_read(off) & ~mask) | (wdata & mask);
        logic [31:0] n_count = m_count;
        logic        n_match = m_match;
        int unsigned n_phase;

        if (ce && !we) m_rdata = model_read(off);
        m_irq = m_match && m_ctrl[2];

        if (wr && off == 3'd2)   n_count = merged;
        else if (tick)           n_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;

        if (hit)                                                n_match = 1'b1;
        else if (wr && off == 3'd4 && mask[0] && wdata[0])      n_match = 1'b0;

        if (!en || (wr && off == 3'd1) || tick) n_phase = 0;
        else                                    n_phase = m_phase + 1;

        if (wr && off == 3'd0) m_ctrl = merged[2:0];
        if (wr && off == 3'd1) m_psc  = merged[15:0];
        if (wr && off == 3'd3) m_cmp  = merged;
        m_count = n_count;
        m_match = n_match;
        m_phase = n_phase;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_cycle(input logic ce, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] hb);
        bus_ce = ce; bus_we = we; bus_addr = addr; bus_wdata = wdata; bus_hb = hb;
        @(posedge clk);
        model_step(ce, we, addr, wdata, hb);
        #1;
        bus_ce = 1'b0;
        bus_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] hb);
        do_cycle(1'b1, 1'b1, addr, data, hb);
    endtask

    task automatic rd(input logic [31:0] addr);
        do_cycle(1'b1, 1'b0, addr, 32'd0, 2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
    endtask

    task automatic apply_reset();
        bus_ce = 1'b0; bus_we = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  hb;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[17];
    logic [31:0] reset_exp[8];

    // ---------------- test sequence ----------------
    initial begin
        int match_edge;
        int irq_edge;
        logic [2:0]  r_off;
        logic [31:0] r_addr;
        logic [31:0] r_data;
        int          r_sel;

        // Reset values of every offset, including the unmapped ones.
        reset_exp = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};

        // Write then read back, with the timer disabled throughout.
        vecs[0]  = '{32'h00, 32'hFFFF_FFFE, 2'b10, 32'h00, 32'h0000_0006};
        vecs[1]  = '{32'h00, 32'h0000_0000, 2'b10, 32'h00, 32'h0000_0000};
        vecs[2]  = '{32'h04, 32'hFFFF_FFFF, 2'b10, 32'h04, 32'h0000_FFFF};
        vecs[3]  = '{32'h06, 32'h1234_0000, 2'b01, 32'h04, 32'h0000_FFFF};
        vecs[4]  = '{32'h04, 32'h0000_0000, 2'b00, 32'h05, 32'h0000_FF00};
        vecs[5]  = '{32'h05, 32'h0000_0000, 2'b00, 32'h04, 32'h0000_0000};
        vecs[6]  = '{32'h0F, 32'hA500_0000, 2'b00, 32'h0C, 32'hA5FF_FFFF};
        vecs[7]  = '{32'h0C, 32'h0000_5A5A, 2'b11, 32'h0E, 32'h0000_5A5A};
        vecs[8]  = '{32'h0E, 32'h00AB_0000, 2'b00, 32'h0C, 32'h00AB_5A5A};
        vecs[9]  = '{32'h14, 32'hFFFF_FFFF, 2'b10, 32'h14, 32'h0000_0000};
        vecs[10] = '{32'h1C, 32'hFFFF_FFFF, 2'b10, 32'h18, 32'h0000_0000};
        vecs[11] = '{32'h08, 32'h0000_0000, 2'b10, 32'h08, 32'h0000_0000};
        vecs[12] = '{32'h0A, 32'h00AB_0000, 2'b00, 32'h08, 32'h00AB_0000};
        vecs[13] = '{32'h08, 32'h0000_0000, 2'b10, 32'h08, 32'h0000_0000};
        vecs[14] = '{32'h08, 32'h0000_1234, 2'b01, 32'h0B, 32'h0000_1234};
        vecs[15] = '{32'h0A, 32'h5678_0000, 2'b01, 32'h08, 32'h5678_1234};
        vecs[16] = '{32'h10, 32'h0000_0001, 2'b10, 32'h10, 32'h0000_0000};

        // Reset values.
        apply_reset();
        check("reset_rdata", bus_rdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd(32'(i * 4));
            check($sformatf("reset_read_0x%02h", i * 4), bus_rdata, reset_exp[i]);
        end

        // Table-driven register access.
        for (int i = 0; i < 17; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata, vecs[i].hb);
            rd(vecs[i].raddr);
            check($sformatf("vec%0d", i), bus_rdata, vecs[i].exp);
        end

        // Prescaled match with auto reload: PRESCALE=3, COMPARE=5.
        apply_reset();
        wr(32'h04, 32'd3, 2'b10);
        wr(32'h0C, 32'd5, 2'b10);
        wr(32'h08, 32'd0, 2'b10);
        wr(32'h00, 32'h7, 2'b10);        // EN takes effect at edge 0
        match_edge = -1;
        irq_edge   = -1;
        for (int n = 1; n <= 40; n++) begin
            rd(32'h10);                  // data reflects state after edge n-1
            if (match_edge < 0 && bus_rdata[0]) match_edge = n - 1;
            if (irq_edge < 0 && irq) irq_edge = n;
            if (match_edge >= 0 && irq_edge >= 0) break;
        end
        check("psc_match_edge", 32'(match_edge), 32'd24);
        check("psc_irq_edge", 32'(irq_edge), 32'd25);
        rd(32'h08);
        check("psc_count_reloaded", bus_rdata, 32'd0);

        // Counter wrap, then match on the following tick without reload.
        apply_reset();
        wr(32'h08, 32'hFFFF_FFFF, 2'b10);
        wr(32'h0C, 32'h0, 2'b10);
        wr(32'h04, 32'h0, 2'b10);
        wr(32'h00, 32'h1, 2'b10);
        idle(1);
        rd(32'h08);
        check("wrap_count", bus_rdata, 32'h0);
        rd(32'h10);
        check("wrap_match", bus_rdata, 32'h1);
        rd(32'h08);
        check("wrap_no_reload_count", bus_rdata, 32'h2);

        // W1C coinciding with a match tick, then a real clear.
        apply_reset();
        wr(32'h04, 32'h0, 2'b10);
        wr(32'h0C, 32'd3, 2'b10);
        wr(32'h08, 32'd0, 2'b10);
        wr(32'h00, 32'h5, 2'b10);
        idle(3);
        wr(32'h10, 32'h1, 2'b10);        // same edge as the match tick
        rd(32'h10);
        check("w1c_race_match", bus_rdata, 32'h1);
        check("w1c_race_irq", {31'd0, irq}, 32'h1);
        wr(32'h10, 32'h1, 2'b10);
        check("w1c_irq_lag", {31'd0, irq}, 32'h1);
        rd(32'h10);
        check("w1c_cleared", bus_rdata, 32'h0);
        check("w1c_irq_low", {31'd0, irq}, 32'h0);

        // Reset in the middle of counting.
        apply_reset();
        wr(32'h04, 32'h0, 2'b10);
        wr(32'h0C, 32'd2, 2'b10);
        wr(32'h08, 32'd0, 2'b10);
        wr(32'h00, 32'h7, 2'b10);
        idle(4);
        rd(32'h08);
        check("pre_reset_count", bus_rdata, 32'h1);
        check("pre_reset_irq", {31'd0, irq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_rdata", bus_rdata, 32'h0);
        check("async_reset_irq", {31'd0, irq}, 32'h0);
        apply_reset();
        idle(5);
        rd(32'h08);
        check("post_reset_count", bus_rdata, 32'h0);
        rd(32'h00);
        check("post_reset_ctrl", bus_rdata, 32'h0);

        // Randomized traffic against the reference model.
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            r_off  = 3'($urandom_range(0, 7));
            r_addr = {27'd0, r_off, 2'($urandom_range(0, 3))};
            case (r_off)
                3'd0:    r_data = 32'($urandom_range(0, 7));
                3'd1:    r_data = 32'($urandom_range(0, 5));
                3'd2:    r_data = 32'($urandom_range(0, 40));
                3'd3:    r_data = 32'($urandom_range(0, 40));
                3'd4:    r_data = 32'($urandom_range(0, 1));
                default: r_data = $urandom;
            endcase
            r_sel = int'($urandom_range(0, 7));
            if (r_sel < 2)
                do_cycle(1'b0, 1'($urandom_range(0, 1)), r_addr, r_data, 2'($urandom_range(0, 3)));
            else if (r_sel < 4)
                do_cycle(1'b1, 1'b1, r_addr, r_data, 2'($urandom_range(0, 3)));
            else
                do_cycle(1'b1, 1'b0, r_addr, r_data, 2'($urandom_range(0, 3)));
            check($sformatf("rand%0d_rdata", n), bus_rdata, m_rdata);
            check($sformatf("rand%0d_irq", n), {31'd0, irq}, {31'd0, m_irq});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
